serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 91 +++++++++
 tb/tb_serial_addsub.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: processes one bit per clock, LSB first, over WIDTH cycles.
// Results are registered on entry to DONE and held until the next result is produced.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             c_q, c_nxt, s_bit;
  logic [CntW-1:0]  cnt_q;

  always_comb begin
    s_bit = a_q[0] ^ b_q[0] ^ c_q;
    c_nxt = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    res_d = res_q >> 1;
    res_d[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            c_q     <= sub;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_nxt;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // On the MSB edge c_q is the carry into the MSB.
            sum      <= res_d;
            carry    <= c_nxt;
            overflow <= c_q ^ c_nxt;
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: an 8-bit instance for the directed vectors and
// a 1-bit instance for the full adder/subtractor truth table.
module tb_serial_addsub;

  typedef struct packed {
    logic [7:0]  sum;
    logic        c;
    logic        ov;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, ov8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, carry1, ov1;
  logic [0:0] sum1;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ov8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ov1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop the expected result whenever the DUT flags done.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check("dut8_spurious_done", 32'(done8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("dut8_result", 32'({sum8, carry8, ov8}), 32'({e8.sum, e8.c, e8.ov}));
        check("dut8_done_cycle", cyc, e8.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        check("dut1_spurious_done", 32'(done1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_result", 32'({sum1, carry1, ov1}), 32'({e1.sum[0], e1.c, e1.ov}));
        check("dut1_done_cycle", cyc, e1.cyc);
      end
    end
  end

  task automatic wait_drain(input bit w1);
    int n;
    n = 0;
    while ((w1 ? q1.size() : q8.size()) != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if ((w1 ? q1.size() : q8.size()) != 0) begin
      check(w1 ? "dut1_done_timeout" : "dut8_done_timeout", 32'd1, 32'd0);
      if (w1) q1.delete(); else q8.delete();
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    q8.push_back('{es, ec, eo, cyc + 8});
    a8 = ~a; b8 = ~b; sub8 = ~s;  // operands are don't-care during RUN
    repeat (8) begin
      @(negedge clk);
      check("dut8_busy_run", 32'({busy8, done8}), 32'b10);
    end
    @(negedge clk);
    check("dut8_busy_done", 32'(busy8), 32'd0);
    wait_drain(1'b0);
  endtask

  task automatic issue1(input logic a, input logic b, input logic s,
                        input logic es, input logic ec, input logic eo);
    @(negedge clk);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    q1.push_back('{{7'd0, es}, ec, eo, cyc + 1});
    a1 = ~a; b1 = ~b; sub1 = ~s;
    @(negedge clk);
    check("dut1_busy_run", 32'({busy1, done1}), 32'b10);
    @(negedge clk);
    check("dut1_busy_done", 32'(busy1), 32'd0);
    wait_drain(1'b1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_dut8", 32'({busy8, done8, sum8, carry8, ov8}), 32'd0);
    check("reset_dut1", 32'({busy1, done1, sum1, carry1, ov1}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-to-back: start held high with the second operands throughout RUN.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h15; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back('{8'h51, 1'b0, 1'b0, cyc + 8});
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    q8.push_back('{8'hF0, 1'b0, 1'b0, cyc + 8});
    start8 = 1'b0;
    wait_drain(1'b0);
    @(negedge clk);
    check("dut8_idle_after_done", 32'({busy8, done8}), 32'd0);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("dut8_async_reset", 32'({busy8, done8, sum8, carry8, ov8}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("dut8_no_done_after_abort", 32'(done8), 32'd0);
    end
    issue8(8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1);

    // WIDTH = 1 full adder/subtractor truth table: a, b, sub -> sum, carry, overflow.
    issue1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    issue1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    issue1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    issue1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
